sfu_stream: RTL and testbench
=============================

// Module: sfu_stream
// PURPOSE
//  Next-generation special function unit: per-channel partial-sum accumulation, saturation and ReLU.
//  Sits between the OFIFO (source) and the PMEM write port (sink).
//  Uses valid/ready handshakes on both sides, a widened accumulator and an explicit op code per beat.
//  Single output register with backpressure; one beat accepted per cycle when not stalled.
// PARAMETERS
//  PSUM_BW   16   signed width of each input lane and each output lane
//  ACC_BW    24   signed accumulator width per lane (must be >= PSUM_BW)
//  COL       8    number of channels (lanes)
//  CNT_BW    8    width of accumulation counter acc_cnt
//  LEAK_SH   3    arithmetic right shift applied to negatives when SFU_LEAKY_RELU_EN is defined
// PORTS
//  clk       in   1              clock, all state on rising edge
//  reset     in   1              synchronous, active-high
//  in_valid  in   1              input beat valid
//  in_ready  out  1              block can accept beat
//  in_op     in   2              00 BYPASS, 01 ACC, 10 FLUSH, 11 ACC_LAST
//  relu_en   in   1              apply ReLU on FLUSH/ACC_LAST beats
//  psum_in   in   PSUM_BW*COL    signed psums, lane i at [PSUM_BW*i +: PSUM_BW]
//  out_valid out  1              output register holds data
//  out_ready in   1              sink accepts output
//  out_data  out  PSUM_BW*COL    result lanes, same packing as psum_in
//  acc_cnt   out  CNT_BW         ACC/ACC_LAST beats since last clear; saturates at all-ones
//  acc_ovf   out  1              sticky: any lane accumulator wrapped since reset
// BEHAVIOUR
//  - Reset: all accumulators 0, out_data 0, out_valid 0, acc_cnt 0, acc_ovf 0, FSM IDLE. Mid-beat reset discards partial state.
//  - Handshake: in_ready = !out_valid | out_ready; combinational, no dependency on in_valid.
//    Transfer when in_valid & in_ready. out_valid/out_data are held stable while out_valid & !out_ready.
//  - Output pop: out_valid clears on out_valid & out_ready, unless a new output-producing beat transfers that same cycle.
//  - Latency: an output-producing beat appears on out_data, out_valid=1, the cycle after its transfer.
//  - BYPASS: out_data <= psum_in unchanged; accumulators, acc_cnt and FSM untouched.
//  - ACC: acc[i] <= acc[i] + sext(psum[i]) in ACC_BW two's complement, wrapping. No output. acc_cnt++. FSM -> ACCUM.
//  - FLUSH: result = f(acc[i]); psum_in ignored; acc cleared, acc_cnt cleared, FSM -> IDLE.
//  - ACC_LAST: result = f(acc[i] + sext(psum[i])); then clears exactly like FLUSH.
//  - f(x): saturate x to signed PSUM_BW range [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
//    If relu_en and the saturated value is negative: 0 (see CONFIGURATION).
//  - acc_ovf: set when any lane's ACC_BW add overflows (operands same sign, sum sign differs). Cleared only by reset.
//  - FSM: IDLE (acc==0) -ACC-> ACCUM; ACCUM -ACC-> ACCUM; any -FLUSH/ACC_LAST-> IDLE.
//    FLUSH in IDLE outputs all zeros.
//  - Simultaneous pop and push: allowed in the same cycle; full throughput at 1 beat/cycle with out_ready=1.
//  - Stall: in_ready=0 for all ops, ACC included, so beat order is preserved.
// CONFIGURATION
//  - SFU_LEAKY_RELU_EN defined: with relu_en=1, a negative saturated value v outputs v >>> LEAK_SH (arithmetic shift).
//  - SFU_LEAKY_RELU_EN undefined: with relu_en=1, negatives output 0. LEAK_SH is unused.
//  - relu_en=0 gives plain saturation in both builds.
// STRUCTURE
//  - Package sfu_pkg holds:
//    - op localparams OP_BYPASS/OP_ACC/OP_FLUSH/OP_ACC_LAST;
//    - FSM state encoding;
//    - function sat_trunc(ACC_BW -> PSUM_BW).
//  - Sub-module sfu_lane, generated COL times: accumulator reg, adder, overflow detect, saturate, (leaky) ReLU.
//  - Top level: handshake, output register, acc_cnt, FSM, OR-reduce of lane overflow flags.
// TESTING
//  Parameters PSUM_BW=16, ACC_BW=24, COL=8.
//  1. BYPASS, lane0=-5 (0xFFFB) -> next cycle out_valid=1, lane0=0xFFFB, acc_cnt stays 0.
//  2. ACC 3, ACC 4, ACC_LAST -10, relu_en=1 -> out lane=0x0000.
//     Same sequence with SFU_LEAKY_RELU_EN, LEAK_SH=3 -> out lane=0xFFFF (-3>>>3).
//  3. ACC 30000, ACC 30000 (acc_cnt=2), FLUSH -> lane=0x7FFF saturated; acc_cnt=0; a following FLUSH -> 0x0000.
//  4. out_ready=0 while out_valid=1 -> in_ready=0 and out_data stable for 5 cycles.
//     Raise out_ready with a pending BYPASS -> pop and push in the same cycle, no beat lost.
//  5. Reset asserted after ACC 100 -> next cycle out_valid=0, acc_cnt=0; a following FLUSH outputs 0.
//  6. 257 ACCs of 0x7FFF on lane7 -> acc wraps past 2^23-1, acc_ovf=1 and stays 1 through FLUSH; acc_cnt saturates at 255.

Source files
------------

// File: rtl/sfu_pkg.sv
// Shared constants, op codes, FSM encoding and saturation helper for the SFU stream block.
// Optional leaky ReLU is enabled by defining SFU_LEAKY_RELU_EN.
package sfu_pkg;

    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned ACC_BW  = 24;
    localparam int unsigned COL     = 8;
    localparam int unsigned CNT_BW  = 8;
    localparam int unsigned LEAK_SH = 3;
    localparam int unsigned DATA_BW = PSUM_BW * COL;

    localparam logic [1:0] OP_BYPASS   = 2'b00;
    localparam logic [1:0] OP_ACC      = 2'b01;
    localparam logic [1:0] OP_FLUSH    = 2'b10;
    localparam logic [1:0] OP_ACC_LAST = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } sfu_state_e;

    // Clamp a signed accumulator value into the signed output lane range.
    function automatic logic [PSUM_BW-1:0] sat_trunc(input logic [ACC_BW-1:0] x);
        logic [ACC_BW-PSUM_BW:0] hi;
        hi = x[ACC_BW-1:PSUM_BW-1];
        if ((hi == '0) || (hi == '1)) begin
            return x[PSUM_BW-1:0];
        end else if (x[ACC_BW-1]) begin
            return {1'b1, {(PSUM_BW-1){1'b0}}};
        end else begin
            return {1'b0, {(PSUM_BW-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/sfu_lane.sv
// One channel: wrapping accumulator, overflow detect, saturation and (leaky) ReLU.
// Leaky negative slope is selected by SFU_LEAKY_RELU_EN.
module sfu_lane
    import sfu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               acc_en,
    input  logic               clr_en,
    input  logic               add_en,
    input  logic               relu_en,
    input  logic [PSUM_BW-1:0] psum,
    output logic [PSUM_BW-1:0] result_c,
    output logic               ovf_c
);

    logic [ACC_BW-1:0]  acc_q;
    logic [ACC_BW-1:0]  acc_d;
    logic [ACC_BW-1:0]  psum_ext;
    logic [ACC_BW-1:0]  sum;
    logic [ACC_BW-1:0]  pre_sat;
    logic [PSUM_BW-1:0] sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        psum_ext = {{(ACC_BW-PSUM_BW){psum[PSUM_BW-1]}}, psum};
        sum      = acc_q + psum_ext;
        // Two's complement overflow: operands agree in sign, sum does not.
        ovf_c    = (acc_q[ACC_BW-1] == psum_ext[ACC_BW-1]) && (sum[ACC_BW-1] != acc_q[ACC_BW-1]);

        acc_d = acc_q;
        if (clr_en) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = sum;
        end

        pre_sat  = add_en ? sum : acc_q;
        sat      = sat_trunc(pre_sat);
        result_c = sat;
        if (relu_en && sat[PSUM_BW-1]) begin
`ifdef SFU_LEAKY_RELU_EN
            result_c = PSUM_BW'($signed(sat) >>> LEAK_SH);
`else
            result_c = '0;
`endif
        end
    end

endmodule

// File: rtl/sfu_stream.sv
// Streaming SFU top: valid/ready handshake, output register, accumulation counter, FSM.
// Build option SFU_LEAKY_RELU_EN selects leaky ReLU in the lanes.
module sfu_stream
    import sfu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic               relu_en,
    input  logic [DATA_BW-1:0] psum_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_BW-1:0] out_data,
    output logic [CNT_BW-1:0]  acc_cnt,
    output logic               acc_ovf
);

    sfu_state_e         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_BW-1:0] out_data_q, out_data_d;
    logic [CNT_BW-1:0]  acc_cnt_q, acc_cnt_d;
    logic               acc_ovf_q, acc_ovf_d;

    logic               xfer;
    logic               is_byp, is_acc, is_flush, is_last, clr;
    logic [DATA_BW-1:0] lane_res;
    logic [COL-1:0]     lane_ovf;

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        xfer     = in_valid && in_ready;
        is_byp   = xfer && (in_op == OP_BYPASS);
        is_acc   = xfer && (in_op == OP_ACC);
        is_flush = xfer && (in_op == OP_FLUSH);
        is_last  = xfer && (in_op == OP_ACC_LAST);
        clr      = is_flush || is_last;
    end

    for (genvar i = 0; i < COL; i++) begin : g_lane
        sfu_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .acc_en   (is_acc),
            .clr_en   (clr),
            .add_en   (in_op == OP_ACC_LAST),
            .relu_en  (relu_en),
            .psum     (psum_in[PSUM_BW*i +: PSUM_BW]),
            .result_c (lane_res[PSUM_BW*i +: PSUM_BW]),
            .ovf_c    (lane_ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_cnt_q   <= '0;
            acc_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_ovf_q   <= acc_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_cnt_d   = acc_cnt_q;
        acc_ovf_d   = acc_ovf_q;

        unique case (state_q)
            ST_IDLE:  if (is_acc) state_d = ST_ACCUM;
            ST_ACCUM: if (clr)    state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase

        // Pop first; a same-cycle producing beat overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (is_byp) begin
            out_valid_d = 1'b1;
            out_data_d  = psum_in;
        end else if (clr) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_res;
        end

        if (clr) begin
            acc_cnt_d = '0;
        end else if (is_acc && (acc_cnt_q != '1)) begin
            acc_cnt_d = acc_cnt_q + CNT_BW'(1);
        end

        if ((is_acc || is_last) && (|lane_ovf)) begin
            acc_ovf_d = 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign acc_cnt   = acc_cnt_q;
    assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_sfu_stream.sv
// Directed and randomized bench for sfu_stream with an integer-arithmetic reference model.
module tb_sfu_stream;
    import sfu_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic               relu_en;
    logic [DATA_BW-1:0] psum_in;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_BW-1:0] out_data;
    logic [CNT_BW-1:0]  acc_cnt;
    logic               acc_ovf;

    int tests = 0;
    int fails = 0;

    longint             m_acc [COL];
    bit                 m_valid;
    logic [DATA_BW-1:0] m_data;
    int                 m_cnt;
    bit                 m_ovf;
    bit                 m_xfer;

    always #5 clk = ~clk;

    sfu_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .relu_en   (relu_en),
        .psum_in   (psum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .acc_cnt   (acc_cnt),
        .acc_ovf   (acc_ovf)
    );

    task automatic chk(input string tag, input logic [DATA_BW-1:0] obs, input logic [DATA_BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        longint span = longint'(1) << ACC_BW;
        longint m    = v & (span - 1);
        if (m >= span / 2) m = m - span;
        return m;
    endfunction

    function automatic longint f_ref(input longint v, input bit relu);
        longint hi = (longint'(1) << (PSUM_BW - 1)) - 1;
        longint lo = -(longint'(1) << (PSUM_BW - 1));
        longint s  = (v > hi) ? hi : ((v < lo) ? lo : v);
        if (relu && s < 0) begin
`ifdef SFU_LEAKY_RELU_EN
            s = s >>> LEAK_SH;
`else
            s = 0;
`endif
        end
        return s;
    endfunction

    function automatic logic [DATA_BW-1:0] lanev(input int lane, input logic [PSUM_BW-1:0] v);
        logic [DATA_BW-1:0] r = '0;
        r[PSUM_BW*lane +: PSUM_BW] = v;
        return r;
    endfunction

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic model_step();
        bit rdy = !m_valid || (out_ready === 1'b1);
        m_xfer = (in_valid === 1'b1) && rdy;
        if (reset === 1'b1) begin
            foreach (m_acc[i]) m_acc[i] = 0;
            m_valid = 0; m_data = '0; m_cnt = 0; m_ovf = 0; m_xfer = 0;
        end else begin
            if (m_valid && out_ready === 1'b1) m_valid = 0;
            if (m_xfer) begin
                if (in_op == OP_BYPASS) begin
                    m_valid = 1;
                    m_data  = psum_in;
                end else begin
                    for (int i = 0; i < int'(COL); i++) begin
                        longint p = longint'($signed(psum_in[PSUM_BW*i +: PSUM_BW]));
                        longint t = m_acc[i] + p;
                        longint w = wrap_acc(t);
                        if (in_op == OP_ACC) begin
                            if (t != w) m_ovf = 1;
                            m_acc[i] = w;
                        end else if (in_op == OP_ACC_LAST) begin
                            if (t != w) m_ovf = 1;
                            m_data[PSUM_BW*i +: PSUM_BW] = PSUM_BW'(f_ref(w, relu_en === 1'b1));
                            m_acc[i] = 0;
                        end else begin
                            m_data[PSUM_BW*i +: PSUM_BW] = PSUM_BW'(f_ref(m_acc[i], relu_en === 1'b1));
                            m_acc[i] = 0;
                        end
                    end
                    if (in_op == OP_ACC) begin
                        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    end else begin
                        m_cnt   = 0;
                        m_valid = 1;
                    end
                end
            end
        end
    endtask

    // One clock: check in_ready, step model, then check registered outputs after the edge.
    task automatic cycle();
        #1;
        chk("in_ready", DATA_BW'(in_ready), DATA_BW'(!m_valid || (out_ready === 1'b1)));
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", DATA_BW'(out_valid), DATA_BW'(m_valid));
        chk("out_data", out_data, m_data);
        chk("acc_cnt", DATA_BW'(acc_cnt), DATA_BW'(m_cnt));
        chk("acc_ovf", DATA_BW'(acc_ovf), DATA_BW'(m_ovf));
    endtask

    task automatic beat(input logic [1:0] op, input bit relu, input logic [DATA_BW-1:0] d);
        bit done = 0;
        in_valid = 1'b1;
        in_op    = op;
        relu_en  = relu;
        psum_in  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            done = m_xfer;
        end
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL beat_timeout observed=no_transfer expected=transfer");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [PSUM_BW-1:0] exp_t2;
        foreach (m_acc[i]) m_acc[i] = 0;
        m_valid = 0; m_data = '0; m_cnt = 0; m_ovf = 0; m_xfer = 0;
        reset = 1'b1; in_valid = 1'b0; in_op = OP_BYPASS; relu_en = 1'b0;
        psum_in = '0; out_ready = 1'b1;
        @(posedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_out_valid", DATA_BW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_acc_cnt", DATA_BW'(acc_cnt), '0);

        // Bypass of a negative lane value
        beat(OP_BYPASS, 1'b0, lanev(0, 16'hFFFB));
        chk("t1_lane0", DATA_BW'(out_data[15:0]), DATA_BW'(16'hFFFB));
        chk("t1_valid", DATA_BW'(out_valid), DATA_BW'(1'b1));
        chk("t1_cnt", DATA_BW'(acc_cnt), '0);

        // 3 + 4 - 10 = -3 with ReLU
        beat(OP_ACC, 1'b0, lanev(0, 16'd3));
        beat(OP_ACC, 1'b0, lanev(0, 16'd4));
        beat(OP_ACC_LAST, 1'b1, lanev(0, 16'hFFF6));
`ifdef SFU_LEAKY_RELU_EN
        exp_t2 = 16'hFFFF;
`else
        exp_t2 = 16'h0000;
`endif
        chk("t2_lane0", DATA_BW'(out_data[15:0]), DATA_BW'(exp_t2));
        chk("t2_cnt", DATA_BW'(acc_cnt), '0);

        // Positive saturation, then an empty flush
        beat(OP_ACC, 1'b0, lanev(0, 16'd30000));
        beat(OP_ACC, 1'b0, lanev(0, 16'd30000));
        chk("t3_cnt2", DATA_BW'(acc_cnt), DATA_BW'(8'd2));
        beat(OP_FLUSH, 1'b0, lanev(0, 16'h1111));
        chk("t3_sat", DATA_BW'(out_data[15:0]), DATA_BW'(16'h7FFF));
        chk("t3_cnt0", DATA_BW'(acc_cnt), '0);
        beat(OP_FLUSH, 1'b0, lanev(0, 16'h2222));
        chk("t3_empty", out_data, '0);

        // Backpressure hold, then simultaneous pop and push
        beat(OP_BYPASS, 1'b0, lanev(1, 16'h1234));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_BYPASS;
        psum_in   = lanev(2, 16'h0055);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t4_in_ready", DATA_BW'(in_ready), '0);
            chk("t4_hold", out_data, lanev(1, 16'h1234));
        end
        out_ready = 1'b1;
        cycle();
        chk("t4_push", out_data, lanev(2, 16'h0055));
        chk("t4_valid", DATA_BW'(out_valid), DATA_BW'(1'b1));
        in_valid = 1'b0;
        cycle();
        chk("t4_pop", DATA_BW'(out_valid), '0);

        // Reset mid-accumulation discards partial sums
        beat(OP_ACC, 1'b0, lanev(3, 16'd100));
        reset = 1'b1;
        cycle();
        chk("t5_valid", DATA_BW'(out_valid), '0);
        chk("t5_cnt", DATA_BW'(acc_cnt), '0);
        reset = 1'b0;
        beat(OP_FLUSH, 1'b0, '0);
        chk("t5_flush", out_data, '0);

        // Accumulator wrap, sticky overflow, counter saturation
        for (int k = 0; k < 257; k++) beat(OP_ACC, 1'b0, lanev(7, 16'h7FFF));
        chk("t6_ovf", DATA_BW'(acc_ovf), DATA_BW'(1'b1));
        chk("t6_cnt", DATA_BW'(acc_cnt), DATA_BW'(8'hFF));
        beat(OP_FLUSH, 1'b0, '0);
        chk("t6_ovf_sticky", DATA_BW'(acc_ovf), DATA_BW'(1'b1));
        chk("t6_lane7", DATA_BW'(out_data[127:112]), DATA_BW'(16'h8000));

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            relu_en   = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(COL); i++) begin
                psum_in[PSUM_BW*i +: PSUM_BW] = ($urandom_range(0, 1) == 1) ?
                    PSUM_BW'($urandom) : PSUM_BW'($signed(8'($urandom)));
            end
            cycle();
        end
        reset = 1'b0;
        out_ready = 1'b1;
        beat(OP_FLUSH, 1'b1, '0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
